decode_stage_rf: RTL and testbench

Parametrised Y86-64 decode stage with an integrated, writable register file. Covers source/destination selection, five-source operand forwarding, load-use hazard detection and the D→E pipeline register with bubble insertion. Sits between fetch/D-register and execute. Writeback writes the register file directly through two write ports (E and M).

---
 rtl/decode_stage_rf.sv | 179 +++++++++++++++++
 tb/tb_decode_stage_rf.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_rf.sv
// Y86-64 decode stage: register selection, five-source operand forwarding,
// load-use detection, writable register file and the D->E pipeline register.
module decode_stage_rf #(
  parameter int XLEN   = 64,
  parameter int NREG   = 15,
  parameter int RIDX_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              D_valid_i,
  input  logic [3:0]        D_icode_i,
  input  logic [3:0]        D_ifun_i,
  input  logic [RIDX_W-1:0] D_rA_i,
  input  logic [RIDX_W-1:0] D_rB_i,
  input  logic [XLEN-1:0]   D_valC_i,
  input  logic [XLEN-1:0]   D_valP_i,

  input  logic [RIDX_W-1:0] e_dstE_i,
  input  logic [XLEN-1:0]   e_valE_i,
  input  logic [RIDX_W-1:0] M_dstM_i,
  input  logic [XLEN-1:0]   m_valM_i,
  input  logic [RIDX_W-1:0] M_dstE_i,
  input  logic [XLEN-1:0]   M_valE_i,
  input  logic [RIDX_W-1:0] W_dstM_i,
  input  logic [XLEN-1:0]   W_valM_i,
  input  logic [RIDX_W-1:0] W_dstE_i,
  input  logic [XLEN-1:0]   W_valE_i,

  input  logic              E_bubble_i,
  output logic              d_stall_o,

  output logic              E_valid_o,
  output logic [3:0]        E_icode_o,
  output logic [3:0]        E_ifun_o,
  output logic [XLEN-1:0]   E_valC_o,
  output logic [XLEN-1:0]   E_valA_o,
  output logic [XLEN-1:0]   E_valB_o,
  output logic [RIDX_W-1:0] E_dstE_o,
  output logic [RIDX_W-1:0] E_dstM_o,
  output logic [RIDX_W-1:0] E_srcA_o,
  output logic [RIDX_W-1:0] E_srcB_o
);

  localparam logic [RIDX_W-1:0] RNONE = '1;
  localparam logic [RIDX_W-1:0] RSP   = RIDX_W'(4);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  logic [XLEN-1:0]   rf [NREG];

  logic [RIDX_W-1:0] src_a;
  logic [RIDX_W-1:0] src_b;
  logic [RIDX_W-1:0] dst_e;
  logic [RIDX_W-1:0] dst_m;
  logic [XLEN-1:0]   val_a;
  logic [XLEN-1:0]   val_b;
  logic              load_use;

  // Index is a real architectural register (not RNONE and inside the file).
  function automatic logic reg_ok(input logic [RIDX_W-1:0] idx);
    return (idx != RNONE) && (int'(idx) < NREG);
  endfunction

  // Newest producer wins; the file is only consulted when no stage matches.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [RIDX_W-1:0] src);
    logic [XLEN-1:0] val;
    val = '0;
    if (reg_ok(src)) begin
      if      (src == e_dstE_i) val = e_valE_i;
      else if (src == M_dstM_i) val = m_valM_i;
      else if (src == M_dstE_i) val = M_valE_i;
      else if (src == W_dstM_i) val = W_valM_i;
      else if (src == W_dstE_i) val = W_valE_i;
      else                      val = rf[src];
    end
    return val;
  endfunction

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    if (D_valid_i) begin
      case (D_icode_i)
        I_RRMOVQ: begin src_a = D_rA_i; dst_e = D_rB_i; end
        I_IRMOVQ: dst_e = D_rB_i;
        I_RMMOVQ: begin src_a = D_rA_i; src_b = D_rB_i; end
        I_MRMOVQ: begin src_b = D_rB_i; dst_m = D_rA_i; end
        I_OPQ:    begin src_a = D_rA_i; src_b = D_rB_i; dst_e = D_rB_i; end
        I_CALL:   begin src_b = RSP; dst_e = RSP; end
        I_RET:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
        I_PUSHQ:  begin src_a = D_rA_i; src_b = RSP; dst_e = RSP; end
        I_POPQ:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = D_rA_i; end
        default:  ;
      endcase
    end
  end

  always_comb begin
    val_b = fwd_sel(src_b);
    if (D_icode_i == I_CALL || D_icode_i == I_JXX) val_a = D_valP_i;
    else                                           val_a = fwd_sel(src_a);
  end

  // A load in E cannot forward until it reaches M, so a dependent D waits.
  assign load_use = E_valid_o
                  && (E_icode_o == I_MRMOVQ || E_icode_o == I_POPQ)
                  && (E_dstM_o != RNONE)
                  && (E_dstM_o == src_a || E_dstM_o == src_b);
  assign d_stall_o = load_use && !rst_i;

  // NOTE: the register file is a small flop array, so it is cleared on reset
  // like any other state; a RAM macro could not be initialised this way.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments; when both ports name one register
      // the later assignment (the M port) is the one that takes effect.
      if (reg_ok(W_dstE_i)) rf[W_dstE_i] <= W_valE_i;
      if (reg_ok(W_dstM_i)) rf[W_dstM_i] <= W_valM_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      E_valid_o <= 1'b0;
      E_icode_o <= I_NOP;
      E_ifun_o  <= '0;
      E_valC_o  <= '0;
      E_valA_o  <= '0;
      E_valB_o  <= '0;
      E_dstE_o  <= RNONE;
      E_dstM_o  <= RNONE;
      E_srcA_o  <= RNONE;
      E_srcB_o  <= RNONE;
    end else if (load_use || E_bubble_i) begin
      E_valid_o <= 1'b0;
      E_icode_o <= I_NOP;
      E_ifun_o  <= '0;
      E_valC_o  <= '0;
      E_valA_o  <= '0;
      E_valB_o  <= '0;
      E_dstE_o  <= RNONE;
      E_dstM_o  <= RNONE;
      E_srcA_o  <= RNONE;
      E_srcB_o  <= RNONE;
    end else begin
      E_valid_o <= D_valid_i;
      E_icode_o <= D_icode_i;
      E_ifun_o  <= D_ifun_i;
      E_valC_o  <= D_valC_i;
      E_valA_o  <= val_a;
      E_valB_o  <= val_b;
      E_dstE_o  <= dst_e;
      E_dstM_o  <= dst_m;
      E_srcA_o  <= src_a;
      E_srcB_o  <= src_b;
    end
  end

endmodule

// File: tb/tb_decode_stage_rf.sv
// Self-checking bench for decode_stage_rf: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_decode_stage_rf;

  localparam int XLEN   = 64;
  localparam int NREG   = 15;
  localparam int RIDX_W = 4;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] NOP = 4'h1, RRMOVQ = 4'h2, IRMOVQ = 4'h3, MRMOVQ = 4'h5,
                         OPQ = 4'h6, JXX = 4'h7, CALL = 4'h8, POPQ = 4'hB;

  logic              clk, rst;
  logic              D_valid;
  logic [3:0]        D_icode, D_ifun;
  logic [RIDX_W-1:0] D_rA, D_rB;
  logic [XLEN-1:0]   D_valC, D_valP;
  logic [RIDX_W-1:0] e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [XLEN-1:0]   e_valE, m_valM, M_valE, W_valM, W_valE;
  logic              E_bubble;
  logic              d_stall;
  logic              E_valid;
  logic [3:0]        E_icode, E_ifun;
  logic [XLEN-1:0]   E_valC, E_valA, E_valB;
  logic [RIDX_W-1:0] E_dstE, E_dstM, E_srcA, E_srcB;

  decode_stage_rf #(.XLEN(XLEN), .NREG(NREG), .RIDX_W(RIDX_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .D_valid_i(D_valid), .D_icode_i(D_icode), .D_ifun_i(D_ifun),
    .D_rA_i(D_rA), .D_rB_i(D_rB), .D_valC_i(D_valC), .D_valP_i(D_valP),
    .e_dstE_i(e_dstE), .e_valE_i(e_valE), .M_dstM_i(M_dstM), .m_valM_i(m_valM),
    .M_dstE_i(M_dstE), .M_valE_i(M_valE), .W_dstM_i(W_dstM), .W_valM_i(W_valM),
    .W_dstE_i(W_dstE), .W_valE_i(W_valE),
    .E_bubble_i(E_bubble), .d_stall_o(d_stall),
    .E_valid_o(E_valid), .E_icode_o(E_icode), .E_ifun_o(E_ifun),
    .E_valC_o(E_valC), .E_valA_o(E_valA), .E_valB_o(E_valB),
    .E_dstE_o(E_dstE), .E_dstM_o(E_dstM), .E_srcA_o(E_srcA), .E_srcB_o(E_srcB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            valid;
    logic [3:0]      icode, ifun;
    logic [XLEN-1:0] valc, vala, valb;
    logic [3:0]      dste, dstm, srca, srcb;
  } e_t;

  typedef struct packed {
    logic [3:0] srca, srcb, dste, dstm;
  } dec_t;

  e_t              m_e;
  logic [XLEN-1:0] regs [NREG];
  int              n_checks = 0;
  int              n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic e_t bubble_e();
    e_t b;
    b = '0;
    b.icode = NOP;
    b.dste = RNONE; b.dstm = RNONE; b.srca = RNONE; b.srcb = RNONE;
    return b;
  endfunction

  // Register roles per instruction class, read straight off the ISA table.
  function automatic dec_t decode_model();
    dec_t d;
    d = '{RNONE, RNONE, RNONE, RNONE};
    if (D_valid) begin
      if (D_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) d.srca = D_rA;
      if (D_icode inside {4'h9, 4'hB})             d.srca = RSP;
      if (D_icode inside {4'h6, 4'h4, 4'h5})       d.srcb = D_rB;
      if (D_icode inside {4'h8, 4'hA, 4'hB, 4'h9}) d.srcb = RSP;
      if (D_icode inside {4'h2, 4'h3, 4'h6})       d.dste = D_rB;
      if (D_icode inside {4'hA, 4'hB, 4'h8, 4'h9}) d.dste = RSP;
      if (D_icode inside {4'h5, 4'hB})             d.dstm = D_rA;
    end
    return d;
  endfunction

  function automatic logic [XLEN-1:0] value_of(input logic [3:0] s);
    logic [3:0]      dsts [5];
    logic [XLEN-1:0] vals [5];
    dsts = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (s == RNONE || int'(s) >= NREG) return '0;
    for (int k = 0; k < 5; k++)
      if (dsts[k] == s) return vals[k];
    return regs[s];
  endfunction

  // Compare process: at each falling edge check the DUT against the model,
  // then advance the model with the inputs the next rising edge will sample.
  initial begin
    dec_t d;
    logic exp_stall;
    e_t   nxt;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_e = bubble_e();
        for (int r = 0; r < NREG; r++) regs[r] = '0;
      end
      d = decode_model();
      exp_stall = !rst && m_e.valid && (m_e.icode == MRMOVQ || m_e.icode == POPQ)
                  && m_e.dstm != RNONE && (m_e.dstm == d.srca || m_e.dstm == d.srcb);
      check("stall",   64'(d_stall), 64'(exp_stall));
      check("E_valid", 64'(E_valid), 64'(m_e.valid));
      check("E_icode", 64'(E_icode), 64'(m_e.icode));
      check("E_ifun",  64'(E_ifun),  64'(m_e.ifun));
      check("E_valC",  E_valC, m_e.valc);
      check("E_valA",  E_valA, m_e.vala);
      check("E_valB",  E_valB, m_e.valb);
      check("E_dstE",  64'(E_dstE), 64'(m_e.dste));
      check("E_dstM",  64'(E_dstM), 64'(m_e.dstm));
      check("E_srcA",  64'(E_srcA), 64'(m_e.srca));
      check("E_srcB",  64'(E_srcB), 64'(m_e.srcb));
      if (!rst) begin
        if (exp_stall || E_bubble) nxt = bubble_e();
        else begin
          nxt.valid = D_valid;
          nxt.icode = D_icode;
          nxt.ifun  = D_ifun;
          nxt.valc  = D_valC;
          nxt.vala  = (D_icode == CALL || D_icode == JXX) ? D_valP : value_of(d.srca);
          nxt.valb  = value_of(d.srcb);
          nxt.dste  = d.dste; nxt.dstm = d.dstm; nxt.srca = d.srca; nxt.srcb = d.srcb;
        end
        if (int'(W_dstE) < NREG) regs[W_dstE] = W_valE;
        if (int'(W_dstM) < NREG) regs[W_dstM] = W_valM;
        m_e = nxt;
      end
    end
  end

  task automatic idle();
    D_valid = 1'b0; D_icode = NOP; D_ifun = '0; D_rA = RNONE; D_rB = RNONE;
    D_valC = '0; D_valP = '0;
    e_dstE = RNONE; M_dstM = RNONE; M_dstE = RNONE; W_dstM = RNONE; W_dstE = RNONE;
    e_valE = '0; m_valM = '0; M_valE = '0; W_valM = '0; W_valE = '0;
    E_bubble = 1'b0;
  endtask

  task automatic set_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp);
    D_valid = 1'b1; D_icode = ic; D_ifun = '0; D_rA = ra; D_rB = rb;
    D_valC = vc; D_valP = vp;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [3:0] rnd_dst();
    return ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : RNONE;
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    #12;
    check("rst_valid", 64'(E_valid), 64'd0);
    check("rst_icode", 64'(E_icode), 64'd1);
    check("rst_dstE",  64'(E_dstE),  64'(RNONE));
    check("rst_stall", 64'(d_stall), 64'd0);
    rst = 1'b0;
    step();

    // IRMOVQ into r2, then writeback and a dependent read from the file.
    set_d(IRMOVQ, RNONE, 4'd2, 64'h1234, 64'h10);
    step();
    check("irmovq_valC", E_valC, 64'h1234);
    check("irmovq_dstE", 64'(E_dstE), 64'd2);
    idle();
    W_dstE = 4'd2; W_valE = 64'h1234;
    step();
    idle();
    set_d(RRMOVQ, 4'd2, 4'd3, 64'h0, 64'h20);
    step();
    check("rf_read_r2", E_valA, 64'h1234);

    // Forwarding priority e > M_dstE > W_dstE.
    idle();
    set_d(OPQ, 4'd3, 4'd3, 64'h0, 64'h30);
    e_dstE = 4'd3; e_valE = 64'hAA;
    M_dstE = 4'd3; M_valE = 64'hBB;
    W_dstE = 4'd3; W_valE = 64'hCC;
    step();
    check("fwd_e_A", E_valA, 64'hAA);
    check("fwd_e_B", E_valB, 64'hAA);
    e_dstE = RNONE;
    step();
    check("fwd_M_A", E_valA, 64'hBB);
    M_dstE = RNONE;
    step();
    check("fwd_W_B", E_valB, 64'hCC);

    // Dual write to r5: the M port wins.
    idle();
    W_dstE = 4'd5; W_valE = 64'h11;
    W_dstM = 4'd5; W_valM = 64'h22;
    step();
    idle();
    set_d(RRMOVQ, 4'd5, 4'd1, 64'h0, 64'h40);
    step();
    check("dual_write_r5", E_valA, 64'h22);

    // Load-use: MRMOVQ into r6 followed by OPQ reading r6.
    idle();
    set_d(MRMOVQ, 4'd6, 4'd7, 64'h8, 64'h50);
    step();
    set_d(OPQ, 4'd6, 4'd1, 64'h0, 64'h60);
    #1;
    check("lu_stall", 64'(d_stall), 64'd1);
    step();
    check("lu_bubble_valid", 64'(E_valid), 64'd0);
    check("lu_bubble_icode", 64'(E_icode), 64'd1);
    check("lu_stall_clear", 64'(d_stall), 64'd0);
    M_dstM = 4'd6; m_valM = 64'h5555;
    step();
    check("lu_fwd_valA", E_valA, 64'h5555);
    check("lu_opq_icode", 64'(E_icode), 64'(OPQ));

    // CALL squashed by a bubble, then passed through.
    idle();
    set_d(CALL, RNONE, RNONE, 64'h900, 64'h400);
    E_bubble = 1'b1;
    step();
    check("bubble_valid", 64'(E_valid), 64'd0);
    check("bubble_icode", 64'(E_icode), 64'd1);
    E_bubble = 1'b0;
    step();
    check("call_valA", E_valA, 64'h400);
    check("call_srcB", 64'(E_srcB), 64'd4);
    check("call_dstE", 64'(E_dstE), 64'd4);

    // Asynchronous reset between edges, then r5 must read back as zero.
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 64'(E_valid), 64'd0);
    check("arst_icode", 64'(E_icode), 64'd1);
    check("arst_valA",  E_valA, 64'd0);
    check("arst_dstE",  64'(E_dstE), 64'(RNONE));
    idle();
    step();
    rst = 1'b0;
    set_d(RRMOVQ, 4'd5, 4'd1, 64'h0, 64'h70);
    step();
    check("post_rst_r5", E_valA, 64'd0);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 400; i++) begin
      D_valid  = ($urandom_range(0, 7) != 0);
      D_icode  = 4'($urandom_range(0, 15));
      D_ifun   = 4'($urandom_range(0, 15));
      D_rA     = ($urandom_range(0, 7) == 0) ? RNONE : 4'($urandom_range(0, 7));
      D_rB     = ($urandom_range(0, 7) == 0) ? RNONE : 4'($urandom_range(0, 7));
      D_valC   = {$urandom, $urandom};
      D_valP   = {$urandom, $urandom};
      e_dstE   = rnd_dst(); e_valE = {$urandom, $urandom};
      M_dstM   = rnd_dst(); m_valM = {$urandom, $urandom};
      M_dstE   = rnd_dst(); M_valE = {$urandom, $urandom};
      W_dstM   = rnd_dst(); W_valM = {$urandom, $urandom};
      W_dstE   = rnd_dst(); W_valE = {$urandom, $urandom};
      E_bubble = ($urandom_range(0, 9) == 0);
      step();
    end

    idle();
    step();
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
